// File: rtl/cell_array_arbiter_if.sv
// Client-side request/grant bundle for cell_array_arbiter: two clients, each
// with its own request fields, sharing one registered read-data return.
interface cell_array_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, done0, done1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, done0, done1, rdata
    );
endinterface

// File: rtl/cell_array_arbiter.sv
// Two-client arbiter/sequencer for a word-organised binary cell array.
// Define CELL_ARB_FIXED_PRIO_EN for fixed client-0 priority (default: round-robin).
module cell_array_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cell_array_arbiter_if.slave       bus,
    output logic [(1<<ADDR_W)-1:0]    cs,
    output logic                      w,
    output logic                      r,
    output logic [DATA_W-1:0]         din,
    input  logic [DATA_W-1:0]         dout
);
    localparam int CS_W = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } creq_t;

    state_t            state;
    logic [1:0]        req;
    creq_t [1:0]       creq;
    creq_t             sel;
    logic              win;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [DATA_W-1:0] rdata_q;

    assign req     = {bus.req1, bus.req0};
    assign creq[0] = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
    assign creq[1] = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
    assign sel     = creq[win];

`ifdef CELL_ARB_FIXED_PRIO_EN
    // Client 0 always wins a tie; client 1 only gets in when client 0 is idle.
    always_comb begin
        win = ~req[0];
    end
`else
    logic ptr;

    always_comb begin
        win = (req[0] & req[1]) ? ptr : req[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (state == IDLE && (req[0] | req[1]))
            ptr <= ~win;
    end
`endif

    // cs/w/r/din double as the latched request: they are loaded at the grant
    // edge and the client inputs are not looked at again until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            cs      <= '0;
            w       <= 1'b0;
            r       <= 1'b0;
            din     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (req[0] | req[1]) begin
                        state <= ACCESS;
                        gnt   <= win ? 2'b10 : 2'b01;
                        cs    <= {{(CS_W-1){1'b0}}, 1'b1} << sel.addr;
                        w     <= sel.we;
                        r     <= ~sel.we;
                        din   <= sel.wdata;
                    end
                end
                ACCESS: begin
                    state <= DONE;
                    if (r)
                        rdata_q <= dout;
                    done  <= gnt;
                    gnt   <= '0;
                    cs    <= '0;
                    w     <= 1'b0;
                    r     <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    done  <= '0;
                    cs    <= '0;
                    w     <= 1'b0;
                    r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0  = gnt[0];
    assign bus.gnt1  = gnt[1];
    assign bus.done0 = done[0];
    assign bus.done1 = done[1];
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_cell_array_arbiter.sv
// Directed bench for cell_array_arbiter with a behavioural 4x4 cell array.
module tb_cell_array_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cs;
    logic       w, r;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] mem [4];
    int         checks = 0;
    int         errors = 0;

    cell_array_arbiter_if #(.ADDR_W(2), .DATA_W(4)) bus ();

    cell_array_arbiter #(.ADDR_W(2), .DATA_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .cs    (cs),
        .w     (w),
        .r     (r),
        .din   (din),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (w && cs[i]) mem[i] <= din;
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < 4; i++)
            if (cs[i]) dout = dout | mem[i];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int c, input logic v, input logic we,
                           input logic [1:0] a, input logic [3:0] d);
        if (c == 0) begin
            bus.req0 = v; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = v; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE.
    task automatic run_txn(input int c, input logic we, input logic [1:0] a,
                           input logic [3:0] d, input logic [3:0] exp_rd);
        logic [3:0] onehot;
        onehot = 4'b0001 << a;
        set_req(c, 1'b1, we, a, d);
        @(negedge clk);
        check("acc_gnt", {bus.gnt1, bus.gnt0}, (c == 0) ? 2'b01 : 2'b10);
        check("acc_cs", cs, onehot);
        check("acc_wr", {w, r}, we ? 2'b10 : 2'b01);
        if (we) check("acc_din", din, d);
        set_req(c, 1'b0, 1'b0, 2'd0, 4'h0);
        @(negedge clk);
        check("done_pulse", {bus.done1, bus.done0}, (c == 0) ? 2'b01 : 2'b10);
        check("done_strobes", {cs, w, r}, 6'b0);
        if (!we) check("done_rdata", bus.rdata, exp_rd);
        @(negedge clk);
        check("idle_quiet", {bus.done1, bus.done0, bus.gnt1, bus.gnt0}, 4'b0);
    endtask

    initial begin
        set_req(0, 1'b0, 1'b0, 2'd0, 4'h0);
        set_req(1, 1'b0, 1'b0, 2'd0, 4'h0);
        #12;
        check("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b0);
        check("rst_done", {bus.done1, bus.done0}, 2'b0);
        check("rst_strobes", {cs, w, r}, 6'b0);
        check("rst_din", din, 4'h0);
        check("rst_rdata", bus.rdata, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // client 0 write then read addr 2
        run_txn(0, 1'b1, 2'd2, 4'hA, 4'h0);
        run_txn(0, 1'b0, 2'd2, 4'h0, 4'hA);

        // both clients requesting straight out of reset
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b1, 2'd1, 4'h5);
        set_req(1, 1'b1, 1'b1, 2'd3, 4'hC);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
`ifdef CELL_ARB_FIXED_PRIO_EN
            check("rr_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
`else
            check("rr_gnt", {bus.gnt1, bus.gnt0}, (s % 2 == 0) ? 2'b01 : 2'b10);
`endif
            if (s == 3) begin
                set_req(0, 1'b0, 1'b0, 2'd0, 4'h0);
                set_req(1, 1'b0, 1'b0, 2'd0, 4'h0);
            end
            @(negedge clk);
            check("rr_done_strb", {cs, w, r}, 6'b0);
            @(negedge clk);
            check("rr_idle_gnt", {bus.gnt1, bus.gnt0}, 2'b0);
        end
        run_txn(0, 1'b0, 2'd1, 4'h0, 4'h5);
`ifndef CELL_ARB_FIXED_PRIO_EN
        run_txn(1, 1'b0, 2'd3, 4'h0, 4'hC);
`endif

        // preload 1..4 then back-to-back reads from client 1
        for (int i = 0; i < 4; i++)
            run_txn(1, 1'b1, 2'(i), 4'(i + 1), 4'h0);
        set_req(1, 1'b1, 1'b0, 2'd0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_gnt", {bus.gnt1, bus.gnt0}, 2'b10);
            check("b2b_cs", cs, 4'b0001 << i);
            if (i == 3) set_req(1, 1'b0, 1'b0, 2'd0, 4'h0);
            else        set_req(1, 1'b1, 1'b0, 2'(i + 1), 4'h0);
            @(negedge clk);
            check("b2b_done", {bus.done1, bus.done0}, 2'b10);
            check("b2b_rdata", bus.rdata, 4'(i + 1));
            @(negedge clk);
            check("b2b_idle", {bus.done1, bus.done0}, 2'b00);
        end

        // inputs changed after the grant edge are ignored
        set_req(0, 1'b1, 1'b1, 2'd1, 4'h9);
        @(negedge clk);
        set_req(0, 1'b0, 1'b1, 2'd3, 4'hF);
        check("chg_cs", cs, 4'b0010);
        check("chg_din", din, 4'h9);
        @(negedge clk);
        check("chg_done", bus.done0, 1'b1);
        @(negedge clk);
        run_txn(0, 1'b0, 2'd1, 4'h0, 4'h9);
        run_txn(0, 1'b0, 2'd3, 4'h0, 4'h4);

        // asynchronous reset in the middle of a write access
        set_req(0, 1'b1, 1'b1, 2'd0, 4'h7);
        @(negedge clk);
        check("mid_w", w, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_strobes", {cs, w, r}, 6'b0);
        check("mid_gnt", {bus.gnt1, bus.gnt0}, 2'b0);
        check("mid_rdata", bus.rdata, 4'h0);
        set_req(0, 1'b0, 1'b0, 2'd0, 4'h0);
        @(negedge clk);
        check("mid_nodone", {bus.done1, bus.done0}, 2'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_nodone2", {bus.done1, bus.done0}, 2'b0);
        run_txn(1, 1'b0, 2'd2, 4'h0, 4'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
